td4_cpu: RTL and testbench
==========================

// Module: td4_cpu
// PURPOSE
//  4-bit single-cycle TD4-style CPU core; one instruction executes per clock.
//  The instruction is supplied externally (opecode/imm) from a 16-word program
//  ROM outside this block, indexed by the addr (program counter) output.
//  Holds registers A and B, a carry flag, the PC and a 4-bit LED output register.
// PARAMETERS
//  none (all datapaths fixed at 4 bits)
// PORTS
//  clk      input   1  system clock, all state updates on rising edge
//  n_rst    input   1  reset; asynchronous, active-high (1 = reset asserted)
//  opecode  input   4  opcode of current instruction (ROM[addr][7:4])
//  imm      input   4  immediate of current instruction (ROM[addr][3:0])
//  switch   input   4  input port, sampled at the clock edge by IN A / IN B
//  addr     output  4  program counter, driven straight from the PC register
//  led      output  4  output port, driven straight from the output register
// BEHAVIOUR
//  - Reset (n_rst=1, async): A=0, B=0, carry=0, PC=0, out reg=0, so addr=0 and led=0.
//    Held while n_rst=1; the first instruction executes on the first rising edge after release.
//  - Single 4-bit adder: sum = src + imm, cout = bit 4; src is selected per opcode.
//  - Opcode table (dest <= sum, src):
//      0000 ADD A,Im  A<=A+imm        0001 MOV A,B  A<=B+imm
//      0010 IN  A     A<=switch+imm   0011 MOV A,Im A<=0+imm
//      0100 MOV B,A   B<=A+imm        0101 ADD B,Im B<=B+imm
//      0110 IN  B     B<=switch+imm   0111 MOV B,Im B<=0+imm
//      1001 OUT B     out<=B+imm      1011 OUT Im   out<=0+imm
//      1110 JNC Im    if carry==0 PC<=0+imm, else PC<=PC+1
//      1111 JMP Im    PC<=0+imm
//      others         no register write (src=0); treated as NOP
//  - MOV/IN are encoded with imm=0; the imm add is intentional and not masked.
//  - Carry: every cycle carry <= cout of this cycle's adder (overflow of
//    A+imm etc.), including MOV/IN/OUT/JMP/NOP (cout=0 when src=0).
//  - JNC tests the carry value held *before* this edge (the previous instruction's).
//  - PC: PC<=PC+1 mod 16 (15 wraps to 0) unless a jump is taken.
//  - Latency: results visible on A/B/led/addr one cycle after the issuing
//    edge; no pipelining and no hazards (registers read are pre-edge values).
//  - Only one destination is written per instruction; all others hold.
//  - Reset asserted mid-program clears all state immediately, regardless of clk.
// TESTING
//  1. Reset: n_rst=1 with any opecode/switch -> addr=0, led=0, A=B=0, carry=0;
//     release, opecode=0000 imm=0 -> addr counts 1,2,..,15,0 (wrap).
//  2. switch=3, IN A; MOV B,A; switch=6, IN B; OUT B (all imm=0)
//     -> A=3, then B=3, then B=6, then led=6.
//  3. MOV A,Im 0xE; ADD A,Im 0x3 -> A=0x1, carry=1; next JNC 5 -> not taken,
//     addr=PC+1; ADD A,Im 0 (carry=0) then JNC 5 -> addr=5.
//  4. JMP Im 0x9 from any addr -> addr=9 next cycle; carry=0 afterwards.
//  5. OUT Im 0xA -> led=0xA, holds through later ADD/MOV; undefined opcode
//     1000 -> A, B and led unchanged, addr increments, carry=0.
//  6. Assert n_rst between clock edges mid-program -> all outputs 0 at once.

Source files
------------

// File: rtl/td4_cpu.sv
// TD4-style 4-bit single-cycle CPU core.
// One instruction from an external 16-word ROM executes on each rising clock
// edge. A single 4-bit adder (source + immediate) feeds every destination:
// register A, register B, the LED output register or the program counter.
// The carry flag records that adder's carry-out on every cycle.
module td4_cpu (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [3:0] opecode,
   input  logic [3:0] imm,
   input  logic [3:0] switch,
   output logic [3:0] addr,
   output logic [3:0] led
);

   localparam int DATA_W = 4;

   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] out_reg;
   logic [DATA_W-1:0] pc;
   logic              carry;

   logic [DATA_W-1:0] src;
   logic [DATA_W:0]   sum;
   logic              wr_a;
   logic              wr_b;
   logic              wr_out;
   logic              jump;

   // Decode the opcode into an adder source and a single destination enable
   always_comb begin
      src    = '0;
      wr_a   = 1'b0;
      wr_b   = 1'b0;
      wr_out = 1'b0;
      jump   = 1'b0;
      case (opecode)
         4'b0000: begin src = a_reg;  wr_a = 1'b1; end   // ADD A,Im
         4'b0001: begin src = b_reg;  wr_a = 1'b1; end   // MOV A,B
         4'b0010: begin src = switch; wr_a = 1'b1; end   // IN  A
         4'b0011: begin               wr_a = 1'b1; end   // MOV A,Im
         4'b0100: begin src = a_reg;  wr_b = 1'b1; end   // MOV B,A
         4'b0101: begin src = b_reg;  wr_b = 1'b1; end   // ADD B,Im
         4'b0110: begin src = switch; wr_b = 1'b1; end   // IN  B
         4'b0111: begin               wr_b = 1'b1; end   // MOV B,Im
         4'b1001: begin src = b_reg;  wr_out = 1'b1; end // OUT B
         4'b1011: begin               wr_out = 1'b1; end // OUT Im
         4'b1110: begin jump = ~carry; end               // JNC Im (pre-edge carry)
         4'b1111: begin jump = 1'b1; end                 // JMP Im
         default: ;                                      // undefined: NOP
      endcase
      // The immediate is always added, even for MOV/IN, so imm!=0 is honoured
      sum = {1'b0, src} + {1'b0, imm};
   end

   // Architectural state update; reset clears everything asynchronously
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         out_reg <= '0;
         pc      <= '0;
         carry   <= 1'b0;
      end else begin
         carry <= sum[DATA_W];
         if (wr_a)   a_reg   <= sum[DATA_W-1:0];
         if (wr_b)   b_reg   <= sum[DATA_W-1:0];
         if (wr_out) out_reg <= sum[DATA_W-1:0];
         if (jump)   pc      <= sum[DATA_W-1:0];
         else        pc      <= pc + 4'd1;
      end
   end

   assign addr = pc;
   assign led  = out_reg;

endmodule

// File: tb/tb_td4_cpu.sv
// Directed bench for td4_cpu: reset behaviour, PC wrap, a table of program
// steps with hand-computed addr/led results, and an asynchronous mid-cycle
// reset sequence. Internal A/B/carry are observed through OUT B and JNC.
module tb_td4_cpu;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [3:0] opecode = 4'h0;
   logic [3:0] imm = 4'h0;
   logic [3:0] switch = 4'h0;
   logic [3:0] addr;
   logic [3:0] led;

   int total_cnt = 0;
   int pass_cnt  = 0;

   typedef struct {
      logic [3:0] op;
      logic [3:0] im;
      logic [3:0] sw;
      logic [3:0] exp_addr;
      logic [3:0] exp_led;
   } vec_t;

   vec_t vecs[$];

   td4_cpu dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .opecode (opecode),
      .imm     (imm),
      .switch  (switch),
      .addr    (addr),
      .led     (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
   endtask

   // Apply one instruction at the falling edge, let it execute, sample at the next falling edge
   task automatic step(input logic [3:0] op, input logic [3:0] im, input logic [3:0] sw);
      opecode = op;
      imm     = im;
      switch  = sw;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // ---------------- program table: {op, imm, switch, addr, led} after each step
      vecs.push_back('{4'h2, 4'h0, 4'h3, 4'h1, 4'h0}); // IN A sw=3      A=3
      vecs.push_back('{4'h4, 4'h0, 4'h0, 4'h2, 4'h0}); // MOV B,A        B=3
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h3, 4'h3}); // OUT B          led=3
      vecs.push_back('{4'h6, 4'h0, 4'h6, 4'h4, 4'h3}); // IN B sw=6      B=6
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h5, 4'h6}); // OUT B          led=6
      vecs.push_back('{4'h4, 4'h0, 4'h0, 4'h6, 4'h6}); // MOV B,A        B=3
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h7, 4'h3}); // OUT B          led=3
      vecs.push_back('{4'h3, 4'hE, 4'h0, 4'h8, 4'h3}); // MOV A,E        A=E
      vecs.push_back('{4'h0, 4'h3, 4'h0, 4'h9, 4'h3}); // ADD A,3        A=1 c=1
      vecs.push_back('{4'hE, 4'h5, 4'h0, 4'hA, 4'h3}); // JNC 5 not taken, c=0
      vecs.push_back('{4'h0, 4'h0, 4'h0, 4'hB, 4'h3}); // ADD A,0        c=0
      vecs.push_back('{4'hE, 4'h5, 4'h0, 4'h5, 4'h3}); // JNC 5 taken
      vecs.push_back('{4'h4, 4'h0, 4'h0, 4'h6, 4'h3}); // MOV B,A        B=1
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h7, 4'h1}); // OUT B          led=1
      vecs.push_back('{4'h7, 4'hF, 4'h0, 4'h8, 4'h1}); // MOV B,F        B=F
      vecs.push_back('{4'h5, 4'h1, 4'h0, 4'h9, 4'h1}); // ADD B,1        B=0 c=1
      vecs.push_back('{4'hE, 4'h2, 4'h0, 4'hA, 4'h1}); // JNC 2 not taken
      vecs.push_back('{4'hE, 4'h2, 4'h0, 4'h2, 4'h1}); // JNC 2 taken
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h3, 4'h0}); // OUT B          led=0
      vecs.push_back('{4'h7, 4'h4, 4'h0, 4'h4, 4'h0}); // MOV B,4        B=4
      vecs.push_back('{4'h1, 4'h2, 4'h0, 4'h5, 4'h0}); // MOV A,B +2     A=6
      vecs.push_back('{4'h4, 4'h1, 4'h0, 4'h6, 4'h0}); // MOV B,A +1     B=7
      vecs.push_back('{4'h9, 4'h1, 4'h0, 4'h7, 4'h8}); // OUT B +1       led=8
      vecs.push_back('{4'h0, 4'hF, 4'h0, 4'h8, 4'h8}); // ADD A,F        A=5 c=1
      vecs.push_back('{4'hF, 4'h9, 4'h0, 4'h9, 4'h8}); // JMP 9          c=0
      vecs.push_back('{4'hE, 4'hC, 4'h0, 4'hC, 4'h8}); // JNC C taken (carry cleared by JMP)
      vecs.push_back('{4'hB, 4'hA, 4'h0, 4'hD, 4'hA}); // OUT Im A       led=A
      vecs.push_back('{4'h0, 4'h1, 4'h0, 4'hE, 4'hA}); // ADD A,1        A=6
      vecs.push_back('{4'h7, 4'h2, 4'h0, 4'hF, 4'hA}); // MOV B,2        B=2
      vecs.push_back('{4'h0, 4'hF, 4'h0, 4'h0, 4'hA}); // ADD A,F        A=5 c=1, PC wraps
      vecs.push_back('{4'h8, 4'hF, 4'h0, 4'h1, 4'hA}); // undefined 1000 c=0
      vecs.push_back('{4'hE, 4'h3, 4'h0, 4'h3, 4'hA}); // JNC 3 taken
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h4, 4'h2}); // OUT B          led=2 (B held)
      vecs.push_back('{4'h4, 4'h0, 4'h0, 4'h5, 4'h2}); // MOV B,A        B=5 (A held)
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h6, 4'h5}); // OUT B          led=5
      vecs.push_back('{4'hA, 4'h7, 4'h0, 4'h7, 4'h5}); // undefined 1010
      vecs.push_back('{4'hC, 4'h7, 4'h0, 4'h8, 4'h5}); // undefined 1100
      vecs.push_back('{4'hD, 4'h7, 4'h0, 4'h9, 4'h5}); // undefined 1101
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'hA, 4'h5}); // OUT B          led=5
      vecs.push_back('{4'h2, 4'h1, 4'h9, 4'hB, 4'h5}); // IN A +1 sw=9   A=A
      vecs.push_back('{4'h4, 4'h0, 4'h0, 4'hC, 4'h5}); // MOV B,A        B=A
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'hD, 4'hA}); // OUT B          led=A
      vecs.push_back('{4'h6, 4'h1, 4'hF, 4'hE, 4'hA}); // IN B +1 sw=F   B=0 c=1
      vecs.push_back('{4'hE, 4'h0, 4'h0, 4'hF, 4'hA}); // JNC 0 not taken
      vecs.push_back('{4'h9, 4'h0, 4'h0, 4'h0, 4'h0}); // OUT B          led=0
      vecs.push_back('{4'hB, 4'h7, 4'h0, 4'h1, 4'h7}); // OUT Im 7       led=7
      vecs.push_back('{4'h3, 4'hF, 4'h0, 4'h2, 4'h7}); // MOV A,F        A=F
      vecs.push_back('{4'h0, 4'h3, 4'h0, 4'h3, 4'h7}); // ADD A,3        A=2 c=1

      // ---------------- reset held across edges with an active instruction
      opecode = 4'hB; imm = 4'hF; switch = 4'h5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_addr", addr, 4'h0);
      check("reset_led", led, 4'h0);

      // ---------------- release; ADD A,0 steps PC through 1..15 and wraps to 0
      n_rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step(4'h0, 4'h0, 4'h0);
         check($sformatf("pc_count_%0d", i), addr, 4'(i));
      end
      check("pc_count_led", led, 4'h0);

      // ---------------- table-driven program
      foreach (vecs[i]) begin
         step(vecs[i].op, vecs[i].im, vecs[i].sw);
         check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      end

      // ---------------- asynchronous reset between clock edges (A=2, carry=1 beforehand)
      #2 n_rst = 1'b1;
      #1;
      check("async_rst_addr", addr, 4'h0);
      check("async_rst_led", led, 4'h0);
      @(negedge clk);
      n_rst = 1'b0;
      step(4'hE, 4'h4, 4'h0);              // carry cleared -> JNC taken
      check("post_rst_jnc", addr, 4'h4);
      step(4'h0, 4'h1, 4'h0);              // A cleared -> A=1
      step(4'h4, 4'h0, 4'h0);              // B=1
      step(4'h9, 4'h0, 4'h0);              // led=1
      check("post_rst_a_addr", addr, 4'h7);
      check("post_rst_a_led", led, 4'h1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
